// File: rtl/chess_pkg.sv
// Shared chess encodings: piece codes, colours, board-sequencer state encodings, square helper.
// The SEQ_UN_* states exist only when BOARD_SEQ_UNDO_EN is defined.
package chess_pkg;

    localparam int SQ_W = 6;
    localparam int PC_W = 4;

    localparam logic [2:0] PIECE_NONE   = 3'd0;
    localparam logic [2:0] PIECE_PAWN   = 3'd1;
    localparam logic [2:0] PIECE_KNIGHT = 3'd2;
    localparam logic [2:0] PIECE_BISHOP = 3'd3;
    localparam logic [2:0] PIECE_ROOK   = 3'd4;
    localparam logic [2:0] PIECE_QUEEN  = 3'd5;
    localparam logic [2:0] PIECE_KING   = 3'd6;

    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_INIT    = 3'd1,
        SEQ_MV_CLR  = 3'd2,
        SEQ_MV_SET  = 3'd3
`ifdef BOARD_SEQ_UNDO_EN
        ,
        SEQ_UN_FROM = 3'd4,
        SEQ_UN_TO   = 3'd5
`endif
    } seq_state_e;

    function automatic logic [SQ_W-1:0] sq(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/board_init_rom.sv
// Starting position lookup: square address -> {colour, piece}; purely combinational, no flow control.
// Row 0 holds the black back rank, row 7 the white one.
module board_init_rom
    import chess_pkg::*;
(
    input  logic [SQ_W-1:0] addr,
    output logic [PC_W-1:0] piece
);

    logic [2:0] back;

    always_comb begin
        case (addr[2:0])
            3'd0, 3'd7: back = PIECE_ROOK;
            3'd1, 3'd6: back = PIECE_KNIGHT;
            3'd2, 3'd5: back = PIECE_BISHOP;
            3'd3:       back = PIECE_QUEEN;
            default:    back = PIECE_KING;
        endcase

        case (addr[5:3])
            3'd0:    piece = {COLOR_BLACK, back};
            3'd1:    piece = {COLOR_BLACK, PIECE_PAWN};
            3'd6:    piece = {COLOR_WHITE, PIECE_PAWN};
            3'd7:    piece = {COLOR_WHITE, back};
            default: piece = {COLOR_WHITE, PIECE_NONE};
        endcase
    end

endmodule

// File: rtl/board_write_sequencer.sv
// Sole writer of the board array: 64-cycle initial load, two-write move commit, optional undo (BOARD_SEQ_UNDO_EN).
// First write one cycle after accept; requests seen outside IDLE are dropped, never stalled.
module board_write_sequencer
    import chess_pkg::*;
#(
    parameter int SQUARES = 64,
    parameter int PIECE_W = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [SQUARES*PIECE_W-1:0] board_in,
    input  logic                       init_req,
    input  logic                       move_req,
    input  logic [5:0]                 move_from,
    input  logic [5:0]                 move_to,
    input  logic [PIECE_W-1:0]         move_piece,
    input  logic                       undo_req,
    output logic                       wr_en,
    output logic [5:0]                 wr_addr,
    output logic [PIECE_W-1:0]         wr_data,
    output logic                       busy,
    output logic                       board_valid,
    output logic                       done,
    output logic                       err,
    output logic [PIECE_W-1:0]         captured
);

    seq_state_e         state_q, state_d;
    logic [5:0]         addr_q, addr_d;
    logic               wr_en_q, wr_en_d;
    logic [5:0]         wr_addr_q, wr_addr_d;
    logic [PIECE_W-1:0] wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               board_valid_q, board_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [PIECE_W-1:0] captured_q, captured_d;
    logic [5:0]         to_q, to_d;
    logic [PIECE_W-1:0] piece_q, piece_d;
`ifdef BOARD_SEQ_UNDO_EN
    logic [5:0]         from_q, from_d;
    logic [PIECE_W-1:0] orig_q, orig_d;
    logic               log_valid_q, log_valid_d;
`else
    logic               unused_undo_req;
    assign unused_undo_req = undo_req;
`endif

    logic [PIECE_W-1:0] square [SQUARES];
    logic [5:0]         init_addr;
    logic [5:0]         rom_addr;
    logic [PIECE_W-1:0] rom_piece;

    always_comb begin
        for (int i = 0; i < SQUARES; i++) begin
            square[i] = board_in[i*PIECE_W +: PIECE_W];
        end
    end

    // Straight out of reset nothing has been written yet, so the load starts at addr_q itself.
    always_comb begin
        init_addr = wr_en_q ? addr_q + 6'd1 : addr_q;
        rom_addr  = (state_q == SEQ_INIT) ? init_addr : 6'd0;
    end

    board_init_rom u_rom (
        .addr  (rom_addr),
        .piece (rom_piece)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = '0;
        wr_data_d     = '0;
        board_valid_d = board_valid_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        captured_d    = captured_q;
        to_d          = to_q;
        piece_d       = piece_q;
`ifdef BOARD_SEQ_UNDO_EN
        from_d        = from_q;
        orig_d        = orig_q;
        log_valid_d   = log_valid_q;
`endif

        case (state_q)
            SEQ_IDLE: begin
                if (init_req) begin
                    state_d       = SEQ_INIT;
                    addr_d        = '0;
                    board_valid_d = 1'b0;
                    wr_en_d       = 1'b1;
                    wr_addr_d     = '0;
                    wr_data_d     = rom_piece;
`ifdef BOARD_SEQ_UNDO_EN
                    log_valid_d   = 1'b0;
`endif
                end
`ifdef BOARD_SEQ_UNDO_EN
                else if (undo_req) begin
                    if (log_valid_q) begin
                        state_d   = SEQ_UN_FROM;
                        wr_en_d   = 1'b1;
                        wr_addr_d = from_q;
                        wr_data_d = orig_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`endif
                else if (move_req) begin
                    if (move_from == move_to) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = SEQ_MV_CLR;
                        to_d       = move_to;
                        piece_d    = move_piece;
                        captured_d = square[move_to];
                        wr_en_d    = 1'b1;
                        wr_addr_d  = move_from;
`ifdef BOARD_SEQ_UNDO_EN
                        from_d     = move_from;
                        orig_d     = square[move_from];
`endif
                    end
                end
            end
            SEQ_INIT: begin
                if (wr_en_q && addr_q == 6'd63) begin
                    state_d       = SEQ_IDLE;
                    board_valid_d = 1'b1;
                end else begin
                    addr_d    = init_addr;
                    wr_en_d   = 1'b1;
                    wr_addr_d = init_addr;
                    wr_data_d = rom_piece;
                    done_d    = (init_addr == 6'd63);
                end
            end
            SEQ_MV_CLR: begin
                state_d   = SEQ_MV_SET;
                wr_en_d   = 1'b1;
                wr_addr_d = to_q;
                wr_data_d = piece_q;
                done_d    = 1'b1;
            end
            SEQ_MV_SET: begin
                state_d     = SEQ_IDLE;
`ifdef BOARD_SEQ_UNDO_EN
                log_valid_d = 1'b1;
`endif
            end
`ifdef BOARD_SEQ_UNDO_EN
            SEQ_UN_FROM: begin
                state_d   = SEQ_UN_TO;
                wr_en_d   = 1'b1;
                wr_addr_d = to_q;
                wr_data_d = captured_q;
                done_d    = 1'b1;
            end
            SEQ_UN_TO: begin
                state_d     = SEQ_IDLE;
                log_valid_d = 1'b0;
            end
`endif
            default: state_d = SEQ_IDLE;
        endcase

        busy_d = (state_d != SEQ_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= SEQ_INIT;
            addr_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            board_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            captured_q    <= '0;
            to_q          <= '0;
            piece_q       <= '0;
`ifdef BOARD_SEQ_UNDO_EN
            from_q        <= '0;
            orig_q        <= '0;
            log_valid_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            board_valid_q <= board_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
            captured_q    <= captured_d;
            to_q          <= to_d;
            piece_q       <= piece_d;
`ifdef BOARD_SEQ_UNDO_EN
            from_q        <= from_d;
            orig_q        <= orig_d;
            log_valid_q   <= log_valid_d;
`endif
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign board_valid = board_valid_q;
    assign done        = done_q;
    assign err         = err_q;
    assign captured    = captured_q;

endmodule

// File: tb/tb_board_write_sequencer.sv
// Bench for board_write_sequencer: directed scenarios plus random move/undo traffic against a board model.
// Undo expectations follow BOARD_SEQ_UNDO_EN.
module tb_board_write_sequencer;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [255:0] board_in;
    logic         init_req, move_req, undo_req;
    logic [5:0]   move_from, move_to;
    logic [3:0]   move_piece;
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [3:0]   wr_data;
    logic         busy, board_valid, done, err;
    logic [3:0]   captured;

    int total = 0;
    int bad   = 0;

    logic [3:0] mb [64];
    logic [3:0] start_pos [64];
    bit         m_log_valid;
    int         m_from, m_to;
    logic [3:0] m_orig, m_cap;

    always #5 CLK = ~CLK;

    board_write_sequencer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .board_in    (board_in),
        .init_req    (init_req),
        .move_req    (move_req),
        .move_from   (move_from),
        .move_to     (move_to),
        .move_piece  (move_piece),
        .undo_req    (undo_req),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .board_valid (board_valid),
        .done        (done),
        .err         (err),
        .captured    (captured)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_board();
        for (int i = 0; i < 64; i++) board_in[i*4 +: 4] = mb[i];
    endtask

    task automatic build_start_pos();
        int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (r == 0)      start_pos[r*8+c] = 4'(8 + back[c]);
                else if (r == 1) start_pos[r*8+c] = 4'h9;
                else if (r == 6) start_pos[r*8+c] = 4'h1;
                else if (r == 7) start_pos[r*8+c] = 4'(back[c]);
                else             start_pos[r*8+c] = 4'h0;
            end
        end
    endtask

    // Caller sits in the accept/release cycle; a stray move_req is pulsed at load cycle 'inject'.
    task automatic test_init_load(input string tag, input int inject);
        for (int i = 1; i <= 64; i++) begin
            tick();
            init_req = 1'b0;
            undo_req = 1'b0;
            move_req = (i == inject);
            total++;
            if (wr_en !== 1'b1 || wr_addr !== 6'(i-1) || wr_data !== start_pos[i-1] ||
                done !== (i == 64) || busy !== 1'b1 || board_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s load cycle %0d: en=%b addr=%0d data=%h done=%b busy=%b bv=%b, want en=1 addr=%0d data=%h done=%b busy=1 bv=0",
                         tag, i, wr_en, wr_addr, wr_data, done, busy, board_valid, i-1, start_pos[i-1], i == 64);
            end
        end
        tick();
        move_req = 1'b0;
        total++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || board_valid !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s load end: en=%b busy=%b bv=%b done=%b, want 0/0/1/0", tag, wr_en, busy, board_valid, done);
        end
        for (int i = 0; i < 64; i++) mb[i] = start_pos[i];
        m_log_valid = 1'b0;
        push_board();
    endtask

    task automatic do_move(input string tag, input int f, input int t, input logic [3:0] p, input bit poke);
        logic [3:0] cap, orig;
        cap  = mb[t];
        orig = mb[f];
        move_from = 6'(f); move_to = 6'(t); move_piece = p; move_req = 1'b1;
        tick();
        move_req = 1'b0;
        if (f == t) begin
            total++;
            if (err !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL %s err pulse: err=%b en=%b busy=%b, want 1/0/0", tag, err, wr_en, busy);
            end
            tick();
            total++;
            if (err !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL %s after err: err=%b en=%b busy=%b, want 0/0/0", tag, err, wr_en, busy);
            end
            return;
        end
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 6'(f) || wr_data !== 4'h0 || done !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL %s clear: en=%b addr=%0d data=%h done=%b busy=%b err=%b, want 1 %0d 0 0 1 0",
                     tag, wr_en, wr_addr, wr_data, done, busy, err, f);
        end
        if (poke) begin
            move_req = 1'b1; move_from = 6'(t); move_to = 6'(f); move_piece = ~p;
        end
        tick();
        move_req = 1'b0;
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 6'(t) || wr_data !== p || done !== 1'b1 || busy !== 1'b1 || captured !== cap) begin
            bad++;
            $display("FAIL %s set: en=%b addr=%0d data=%h done=%b busy=%b cap=%h, want 1 %0d %h 1 1 %h",
                     tag, wr_en, wr_addr, wr_data, done, busy, captured, t, p, cap);
        end
        tick();
        total++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s idle: en=%b busy=%b done=%b, want 0/0/0", tag, wr_en, busy, done);
        end
        if (poke) begin
            tick();
            total++;
            if (wr_en !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
                bad++;
                $display("FAIL %s dropped poke: en=%b busy=%b err=%b, want 0/0/0", tag, wr_en, busy, err);
            end
        end
        mb[f] = 4'h0;
        mb[t] = p;
        m_log_valid = 1'b1; m_from = f; m_to = t; m_orig = orig; m_cap = cap;
        push_board();
    endtask

    task automatic do_undo(input string tag);
        undo_req = 1'b1;
        tick();
        undo_req = 1'b0;
`ifdef BOARD_SEQ_UNDO_EN
        if (!m_log_valid) begin
            total++;
            if (err !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL %s empty undo: err=%b en=%b busy=%b, want 1/0/0", tag, err, wr_en, busy);
            end
            tick();
            total++;
            if (err !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL %s after empty undo: err=%b en=%b busy=%b, want 0/0/0", tag, err, wr_en, busy);
            end
            return;
        end
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 6'(m_from) || wr_data !== m_orig || done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s undo from: en=%b addr=%0d data=%h done=%b busy=%b, want 1 %0d %h 0 1",
                     tag, wr_en, wr_addr, wr_data, done, busy, m_from, m_orig);
        end
        tick();
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 6'(m_to) || wr_data !== m_cap || done !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s undo to: en=%b addr=%0d data=%h done=%b busy=%b, want 1 %0d %h 1 1",
                     tag, wr_en, wr_addr, wr_data, done, busy, m_to, m_cap);
        end
        tick();
        total++;
        if (wr_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s undo idle: en=%b busy=%b, want 0/0", tag, wr_en, busy);
        end
        mb[m_from] = m_orig;
        mb[m_to]   = m_cap;
        m_log_valid = 1'b0;
        push_board();
`else
        total++;
        if (err !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s undo ignored: err=%b en=%b busy=%b, want 0/0/0", tag, err, wr_en, busy);
        end
        tick();
        total++;
        if (err !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s undo ignored +2: err=%b en=%b busy=%b, want 0/0/0", tag, err, wr_en, busy);
        end
`endif
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) tick();
        total++;
        if (wr_en !== 1'b0 || wr_addr !== 6'd0 || wr_data !== 4'h0 || busy !== 1'b0 ||
            board_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0 || captured !== 4'h0) begin
            bad++;
            $display("FAIL reset outputs: en=%b addr=%0d data=%h busy=%b bv=%b done=%b err=%b cap=%h, want all 0",
                     wr_en, wr_addr, wr_data, busy, board_valid, done, err, captured);
        end
        RESET = 1'b0;
        test_init_load("reset release", 0);
    endtask

    task automatic test_move_basic();
        do_move("move 52-36", 52, 36, 4'h1, 1'b0);
    endtask

    task automatic test_same_square_err();
        do_move("move 9-9", 9, 9, 4'h3, 1'b0);
    endtask

    task automatic test_busy_drop();
        init_req = 1'b1;
        move_from = 6'd3; move_to = 6'd20; move_piece = 4'h7;
        test_init_load("init with stray move", 10);
        do_move("poke at set", 52, 44, 4'h1, 1'b1);
    endtask

    task automatic test_init_priority();
        init_req = 1'b1;
        move_req = 1'b1; move_from = 6'd0; move_to = 6'd40; move_piece = 4'h5;
        test_init_load("init+move", 0);
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (30) tick();
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd30) begin
            bad++;
            $display("FAIL mid-load position: en=%b addr=%0d, want 1 30", wr_en, wr_addr);
        end
        RESET = 1'b1;
        tick();
        total++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || board_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid-load reset: en=%b busy=%b bv=%b done=%b, want 0/0/0/0", wr_en, busy, board_valid, done);
        end
        RESET = 1'b0;
        test_init_load("reload after reset", 0);
    endtask

    task automatic test_undo();
        do_undo("undo empty log");
        do_move("pawn 52-36", 52, 36, 4'h1, 1'b0);
        do_move("capture 36-11", 36, 11, 4'h1, 1'b0);
        do_undo("undo capture");
        do_undo("second undo");
    endtask

    task automatic test_random_ops();
        for (int n = 0; n < 60; n++) begin
            int r, f, t;
            r = int'($urandom_range(0, 9));
            f = int'($urandom_range(0, 63));
            t = int'($urandom_range(0, 63));
            if (r <= 6)      do_move("rand move", f, t, 4'($urandom_range(0, 15)), 1'(r == 0));
            else if (r == 7) do_move("rand same", f, f, 4'($urandom_range(0, 15)), 1'b0);
            else             do_undo("rand undo");
        end
    endtask

    initial begin
        RESET = 1'b1;
        init_req = 1'b0; move_req = 1'b0; undo_req = 1'b0;
        move_from = '0; move_to = '0; move_piece = '0;
        m_log_valid = 1'b0; m_from = 0; m_to = 0; m_orig = '0; m_cap = '0;
        build_start_pos();
        for (int i = 0; i < 64; i++) mb[i] = 4'h0;
        push_board();

        test_reset();
        test_move_basic();
        test_same_square_err();
        test_busy_drop();
        test_init_priority();
        test_undo();
        test_random_ops();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
